// File: rtl/core_pkg.sv
// Shared encodings, control word and decode->execute bundle for the RV32I core.
// Enums for ALU/branch ops and operand selects, plus store/writeback/CSR codes.
package core_pkg;

  typedef enum logic [4:0] {
    ALU_X     = 5'd0,
    ALU_ADD   = 5'd1,
    ALU_SUB   = 5'd2,
    ALU_AND   = 5'd3,
    ALU_OR    = 5'd4,
    ALU_XOR   = 5'd5,
    ALU_SLL   = 5'd6,
    ALU_SRL   = 5'd7,
    ALU_SRA   = 5'd8,
    ALU_SLT   = 5'd9,
    ALU_SLTU  = 5'd10,
    ALU_BEQ   = 5'd11,
    ALU_BNE   = 5'd12,
    ALU_BLT   = 5'd13,
    ALU_BGE   = 5'd14,
    ALU_BLTU  = 5'd15,
    ALU_BGEU  = 5'd16,
    ALU_JALR  = 5'd17,
    ALU_COPY1 = 5'd18
  } exe_fun_t;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_ZERO = 2'd2,
    OP1_IMZ  = 2'd3
  } op1_sel_t;

  typedef enum logic [2:0] {
    OP2_X   = 3'd0,
    OP2_RS2 = 3'd1,
    OP2_IMI = 3'd2,
    OP2_IMS = 3'd3,
    OP2_IMJ = 3'd4,
    OP2_IMU = 3'd5
  } op2_sel_t;

  localparam logic [4:0] MEN_X  = 5'd0;
  localparam logic [4:0] MEN_SB = 5'd1;
  localparam logic [4:0] MEN_SH = 5'd2;
  localparam logic [4:0] MEN_SW = 5'd3;

  localparam logic [3:0] WB_X   = 4'd0;
  localparam logic [3:0] WB_ALU = 4'd1;
  localparam logic [3:0] WB_PC  = 4'd2;
  localparam logic [3:0] WB_CSR = 4'd3;
  localparam logic [3:0] WB_LW  = 4'd4;
  localparam logic [3:0] WB_LB  = 4'd5;
  localparam logic [3:0] WB_LBU = 4'd6;
  localparam logic [3:0] WB_LH  = 4'd7;
  localparam logic [3:0] WB_LHU = 4'd8;

  localparam logic [2:0] CSR_X = 3'd0;
  localparam logic [2:0] CSR_W = 3'd1;
  localparam logic [2:0] CSR_S = 3'd2;
  localparam logic [2:0] CSR_C = 3'd3;
  localparam logic [2:0] CSR_E = 3'd4;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef struct packed {
    logic       valid;
    exe_fun_t   exe_fun;
    op1_sel_t   op1_sel;
    op2_sel_t   op2_sel;
    logic [4:0] mem_wen;
    logic       rf_wen;
    logic [3:0] wb_sel;
    logic [2:0] csr_cmd;
    logic       jmp_flg;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;
    logic [31:0] imm_z;
    logic [31:0] pc;
    exe_fun_t    exe_fun;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] rs2_data;
    logic [4:0]  mem_wen;
    logic        rf_wen;
    logic [3:0]  wb_sel;
    logic [4:0]  wb_addr;
    logic [2:0]  csr_cmd;
    logic        jmp_flg;
  } id_ex_t;

  function automatic ctrl_t mk_ctrl(
    input exe_fun_t   f,
    input op1_sel_t   o1,
    input op2_sel_t   o2,
    input logic [4:0] men,
    input logic       rfw,
    input logic [3:0] wbs,
    input logic [2:0] csr,
    input logic       jmp
  );
    ctrl_t c;
    c.valid   = 1'b1;
    c.exe_fun = f;
    c.op1_sel = o1;
    c.op2_sel = o2;
    c.mem_wen = men;
    c.rf_wen  = rfw;
    c.wb_sel  = wbs;
    c.csr_cmd = csr;
    c.jmp_flg = jmp;
    return c;
  endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Combinational RV32I opcode/funct -> control word; invalid encodings give valid=0.
// Ports: inst (in 32), ctrl (out ctrl_t). SYSTEM decode needs DECODE_CSR_EN.
module decode_ctrl
  import core_pkg::*;
(
  input  logic [31:0] inst,
  output ctrl_t       ctrl
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];

`ifndef DECODE_CSR_EN
  logic unused_fields;
  assign unused_fields = ^{inst[24:15], inst[11:7]};
`endif

  always_comb begin
    exe_fun_t   fun;
    logic [3:0] wbs;
    logic [4:0] men;
    fun  = ALU_X;
    wbs  = WB_X;
    men  = MEN_X;
    ctrl = '0;
    unique case (1'b1)
      (opcode == OP_LUI):
        ctrl = mk_ctrl(ALU_ADD, OP1_ZERO, OP2_IMU,
                       MEN_X, 1'b1, WB_ALU, CSR_X, 1'b0);
      (opcode == OP_AUIPC):
        ctrl = mk_ctrl(ALU_ADD, OP1_PC, OP2_IMU,
                       MEN_X, 1'b1, WB_ALU, CSR_X, 1'b0);
      (opcode == OP_JAL):
        ctrl = mk_ctrl(ALU_ADD, OP1_PC, OP2_IMJ,
                       MEN_X, 1'b1, WB_PC, CSR_X, 1'b1);
      (opcode == OP_JALR): begin
        if (f3 == 3'b000)
          ctrl = mk_ctrl(ALU_JALR, OP1_RS1, OP2_IMI,
                         MEN_X, 1'b1, WB_PC, CSR_X, 1'b1);
      end
      (opcode == OP_BRANCH): begin
        case (f3)
          3'b000:  fun = ALU_BEQ;
          3'b001:  fun = ALU_BNE;
          3'b100:  fun = ALU_BLT;
          3'b101:  fun = ALU_BGE;
          3'b110:  fun = ALU_BLTU;
          3'b111:  fun = ALU_BGEU;
          default: fun = ALU_X;
        endcase
        if (fun != ALU_X)
          ctrl = mk_ctrl(fun, OP1_RS1, OP2_RS2,
                         MEN_X, 1'b0, WB_X, CSR_X, 1'b0);
      end
      (opcode == OP_LOAD): begin
        case (f3)
          3'b000:  wbs = WB_LB;
          3'b001:  wbs = WB_LH;
          3'b010:  wbs = WB_LW;
          3'b100:  wbs = WB_LBU;
          3'b101:  wbs = WB_LHU;
          default: wbs = WB_X;
        endcase
        if (wbs != WB_X)
          ctrl = mk_ctrl(ALU_ADD, OP1_RS1, OP2_IMI,
                         MEN_X, 1'b1, wbs, CSR_X, 1'b0);
      end
      (opcode == OP_STORE): begin
        case (f3)
          3'b000:  men = MEN_SB;
          3'b001:  men = MEN_SH;
          3'b010:  men = MEN_SW;
          default: men = MEN_X;
        endcase
        if (men != MEN_X)
          ctrl = mk_ctrl(ALU_ADD, OP1_RS1, OP2_IMS,
                         men, 1'b0, WB_X, CSR_X, 1'b0);
      end
      (opcode == OP_IMM): begin
        case (f3)
          3'b000: fun = ALU_ADD;
          3'b010: fun = ALU_SLT;
          3'b011: fun = ALU_SLTU;
          3'b100: fun = ALU_XOR;
          3'b110: fun = ALU_OR;
          3'b111: fun = ALU_AND;
          3'b001: fun = (f7 == 7'h00) ? ALU_SLL : ALU_X;
          3'b101: begin
            if (f7 == 7'h00)      fun = ALU_SRL;
            else if (f7 == 7'h20) fun = ALU_SRA;
            else                  fun = ALU_X;
          end
          default: fun = ALU_X;
        endcase
        if (fun != ALU_X)
          ctrl = mk_ctrl(fun, OP1_RS1, OP2_IMI,
                         MEN_X, 1'b1, WB_ALU, CSR_X, 1'b0);
      end
      (opcode == OP_REG): begin
        case ({f7, f3})
          {7'h00, 3'b000}: fun = ALU_ADD;
          {7'h20, 3'b000}: fun = ALU_SUB;
          {7'h00, 3'b001}: fun = ALU_SLL;
          {7'h00, 3'b010}: fun = ALU_SLT;
          {7'h00, 3'b011}: fun = ALU_SLTU;
          {7'h00, 3'b100}: fun = ALU_XOR;
          {7'h00, 3'b101}: fun = ALU_SRL;
          {7'h20, 3'b101}: fun = ALU_SRA;
          {7'h00, 3'b110}: fun = ALU_OR;
          {7'h00, 3'b111}: fun = ALU_AND;
          default:         fun = ALU_X;
        endcase
        if (fun != ALU_X)
          ctrl = mk_ctrl(fun, OP1_RS1, OP2_RS2,
                         MEN_X, 1'b1, WB_ALU, CSR_X, 1'b0);
      end
`ifdef DECODE_CSR_EN
      (opcode == OP_SYSTEM): begin
        case (f3)
          3'b001: ctrl = mk_ctrl(ALU_COPY1, OP1_RS1, OP2_X,
                                 MEN_X, 1'b1, WB_CSR, CSR_W, 1'b0);
          3'b010: ctrl = mk_ctrl(ALU_COPY1, OP1_RS1, OP2_X,
                                 MEN_X, 1'b1, WB_CSR, CSR_S, 1'b0);
          3'b011: ctrl = mk_ctrl(ALU_COPY1, OP1_RS1, OP2_X,
                                 MEN_X, 1'b1, WB_CSR, CSR_C, 1'b0);
          3'b101: ctrl = mk_ctrl(ALU_COPY1, OP1_IMZ, OP2_X,
                                 MEN_X, 1'b1, WB_CSR, CSR_W, 1'b0);
          3'b110: ctrl = mk_ctrl(ALU_COPY1, OP1_IMZ, OP2_X,
                                 MEN_X, 1'b1, WB_CSR, CSR_S, 1'b0);
          3'b111: ctrl = mk_ctrl(ALU_COPY1, OP1_IMZ, OP2_X,
                                 MEN_X, 1'b1, WB_CSR, CSR_C, 1'b0);
          3'b000: begin
            // only the exact ECALL word; EBREAK/MRET etc. bubble
            if (inst[31:7] == 25'd0)
              ctrl = mk_ctrl(ALU_X, OP1_RS1, OP2_X,
                             MEN_X, 1'b0, WB_X, CSR_E, 1'b0);
          end
          default: ctrl = '0;
        endcase
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: regfile read addresses, immediates, operand select, id->ex register.
// Optional SYSTEM/CSR decode via DECODE_CSR_EN; ports: inst/reg_pc in, registered bundle out.
module decode_stage
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic [31:0] reg_pc,
  input  logic        stall,
  input  logic        flush,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_rdata,
  input  logic [31:0] rs2_rdata,
  output logic [31:0] imm_i_sext,
  output logic [31:0] imm_s_sext,
  output logic [31:0] imm_b_sext,
  output logic [31:0] imm_j_sext,
  output logic [31:0] imm_u_shifted,
  output logic [31:0] imm_z_uext,
  output logic [31:0] output_reg_pc,
  output logic [4:0]  exe_fun,
  output logic [31:0] op1_data,
  output logic [31:0] op2_data,
  output logic [31:0] rs2_data,
  output logic [4:0]  mem_wen,
  output logic        rf_wen,
  output logic [3:0]  wb_sel,
  output logic [4:0]  wb_addr,
  output logic [2:0]  csr_cmd,
  output logic        jmp_flg
);

  ctrl_t       ctrl;
  id_ex_t      d;
  id_ex_t      q;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_u;
  logic [31:0] imm_z;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0};
  assign imm_u = {inst[31:12], 12'd0};
  assign imm_z = {27'd0, inst[19:15]};

  // x0 reads as zero no matter what the regfile returns
  assign rs1_val = (rs1_addr == 5'd0) ? 32'd0 : rs1_rdata;
  assign rs2_val = (rs2_addr == 5'd0) ? 32'd0 : rs2_rdata;

  decode_ctrl u_ctrl (
    .inst (inst),
    .ctrl (ctrl)
  );

  always_comb begin
    d          = '0;
    d.imm_i    = imm_i;
    d.imm_s    = imm_s;
    d.imm_b    = imm_b;
    d.imm_j    = imm_j;
    d.imm_u    = imm_u;
    d.imm_z    = imm_z;
    d.pc       = reg_pc;
    d.exe_fun  = ctrl.exe_fun;
    d.rs2_data = rs2_val;
    d.mem_wen  = ctrl.mem_wen;
    d.rf_wen   = ctrl.rf_wen;
    d.wb_sel   = ctrl.wb_sel;
    d.wb_addr  = ctrl.rf_wen ? inst[11:7] : 5'd0;
    d.csr_cmd  = ctrl.csr_cmd;
    d.jmp_flg  = ctrl.jmp_flg;
    case (ctrl.op1_sel)
      OP1_RS1:  d.op1 = rs1_val;
      OP1_PC:   d.op1 = reg_pc;
      OP1_IMZ:  d.op1 = imm_z;
      default:  d.op1 = 32'd0;
    endcase
    case (ctrl.op2_sel)
      OP2_RS2: d.op2 = rs2_val;
      OP2_IMI: d.op2 = imm_i;
      OP2_IMS: d.op2 = imm_s;
      OP2_IMJ: d.op2 = imm_j;
      OP2_IMU: d.op2 = imm_u;
      default: d.op2 = 32'd0;
    endcase
    // illegal encodings travel as a full bubble
    if (!ctrl.valid)
      d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      q <= '0;
    else if (flush)
      q <= '0;
    else if (!stall)
      q <= d;
  end

  assign imm_i_sext    = q.imm_i;
  assign imm_s_sext    = q.imm_s;
  assign imm_b_sext    = q.imm_b;
  assign imm_j_sext    = q.imm_j;
  assign imm_u_shifted = q.imm_u;
  assign imm_z_uext    = q.imm_z;
  assign output_reg_pc = q.pc;
  assign exe_fun       = q.exe_fun;
  assign op1_data      = q.op1;
  assign op2_data      = q.op2;
  assign rs2_data      = q.rs2_data;
  assign mem_wen       = q.mem_wen;
  assign rf_wen        = q.rf_wen;
  assign wb_sel        = q.wb_sel;
  assign wb_addr       = q.wb_addr;
  assign csr_cmd       = q.csr_cmd;
  assign jmp_flg       = q.jmp_flg;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: driver queues expected bundles,
// monitor compares the registered outputs one cycle later.
module tb_decode_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = '0;
  logic [31:0] reg_pc = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_rdata = '0;
  logic [31:0] rs2_rdata = '0;
  logic [31:0] imm_i_sext;
  logic [31:0] imm_s_sext;
  logic [31:0] imm_b_sext;
  logic [31:0] imm_j_sext;
  logic [31:0] imm_u_shifted;
  logic [31:0] imm_z_uext;
  logic [31:0] output_reg_pc;
  logic [4:0]  exe_fun;
  logic [31:0] op1_data;
  logic [31:0] op2_data;
  logic [31:0] rs2_data;
  logic [4:0]  mem_wen;
  logic        rf_wen;
  logic [3:0]  wb_sel;
  logic [4:0]  wb_addr;
  logic [2:0]  csr_cmd;
  logic        jmp_flg;

  int n_chk  = 0;
  int n_fail = 0;
  id_ex_t exp_q[$];
  int     tag_q[$];

  always #5 clk = ~clk;

  decode_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst          (inst),
    .reg_pc        (reg_pc),
    .stall         (stall),
    .flush         (flush),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_rdata     (rs1_rdata),
    .rs2_rdata     (rs2_rdata),
    .imm_i_sext    (imm_i_sext),
    .imm_s_sext    (imm_s_sext),
    .imm_b_sext    (imm_b_sext),
    .imm_j_sext    (imm_j_sext),
    .imm_u_shifted (imm_u_shifted),
    .imm_z_uext    (imm_z_uext),
    .output_reg_pc (output_reg_pc),
    .exe_fun       (exe_fun),
    .op1_data      (op1_data),
    .op2_data      (op2_data),
    .rs2_data      (rs2_data),
    .mem_wen       (mem_wen),
    .rf_wen        (rf_wen),
    .wb_sel        (wb_sel),
    .wb_addr       (wb_addr),
    .csr_cmd       (csr_cmd),
    .jmp_flg       (jmp_flg)
  );

  // immediates derived by shifting a signed copy of the word
  function automatic id_ex_t mk(
    input logic [31:0] in,
    input logic [31:0] pc,
    input exe_fun_t    f,
    input logic [31:0] o1,
    input logic [31:0] o2,
    input logic [31:0] r2d,
    input logic [4:0]  men,
    input logic        rfw,
    input logic [3:0]  wbs,
    input logic [4:0]  wba,
    input logic [2:0]  csr,
    input logic        jmp
  );
    id_ex_t e;
    logic signed [31:0] s;
    logic [31:0] u;
    s = $signed(in);
    u = in;
    e.imm_i    = 32'(s >>> 20);
    e.imm_s    = (32'(s >>> 25) << 5) | ((u >> 7) & 32'h1f);
    e.imm_b    = (32'(s >>> 31) << 12) | (((u >> 7) & 32'h1) << 11)
               | (((u >> 25) & 32'h3f) << 5) | (((u >> 8) & 32'hf) << 1);
    e.imm_j    = (32'(s >>> 31) << 20) | (((u >> 12) & 32'hff) << 12)
               | (((u >> 20) & 32'h1) << 11) | (((u >> 21) & 32'h3ff) << 1);
    e.imm_u    = u & 32'hfffff000;
    e.imm_z    = (u >> 15) & 32'h1f;
    e.pc       = pc;
    e.exe_fun  = f;
    e.op1      = o1;
    e.op2      = o2;
    e.rs2_data = r2d;
    e.mem_wen  = men;
    e.rf_wen   = rfw;
    e.wb_sel   = wbs;
    e.wb_addr  = wba;
    e.csr_cmd  = csr;
    e.jmp_flg  = jmp;
    return e;
  endfunction

  int step_no = 0;

  task automatic step(
    input logic        rn,
    input logic        st,
    input logic        fl,
    input logic [31:0] in,
    input logic [31:0] pc,
    input logic [31:0] r1d,
    input logic [31:0] r2d,
    input id_ex_t      e
  );
    @(negedge clk);
    rst_n     = rn;
    stall     = st;
    flush     = fl;
    inst      = in;
    reg_pc    = pc;
    rs1_rdata = r1d;
    rs2_rdata = r2d;
    #1;
    n_chk++;
    if (rs1_addr !== in[19:15] || rs2_addr !== in[24:20]) begin
      n_fail++;
      $display("FAIL addr step%0d got rs1=%0d rs2=%0d want rs1=%0d rs2=%0d",
               step_no, rs1_addr, rs2_addr, in[19:15], in[24:20]);
    end
    exp_q.push_back(e);
    tag_q.push_back(step_no);
    step_no++;
  endtask

  // monitor: one registered bundle per cycle after each driven step
  initial begin
    id_ex_t e;
    id_ex_t a;
    int     t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a.imm_i    = imm_i_sext;
        a.imm_s    = imm_s_sext;
        a.imm_b    = imm_b_sext;
        a.imm_j    = imm_j_sext;
        a.imm_u    = imm_u_shifted;
        a.imm_z    = imm_z_uext;
        a.pc       = output_reg_pc;
        a.exe_fun  = exe_fun_t'(exe_fun);
        a.op1      = op1_data;
        a.op2      = op2_data;
        a.rs2_data = rs2_data;
        a.mem_wen  = mem_wen;
        a.rf_wen   = rf_wen;
        a.wb_sel   = wb_sel;
        a.wb_addr  = wb_addr;
        a.csr_cmd  = csr_cmd;
        a.jmp_flg  = jmp_flg;
        n_chk++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL out step%0d got=%h want=%h", t, a, e);
        end
      end
    end
  end

  localparam logic [31:0] I_ADDI = 32'h00510093;
  localparam logic [31:0] I_SW   = 32'h00512423;
  localparam logic [31:0] I_BEQ  = 32'h00000463;
  localparam logic [31:0] I_JAL  = 32'hFFDFF0EF;
  localparam logic [31:0] I_LUI  = 32'h123451B7;
  localparam logic [31:0] I_ADD  = 32'h00208233;
  localparam logic [31:0] I_SUB  = 32'h40208233;
  localparam logic [31:0] I_LBU  = 32'h0040C283;
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_JALR = 32'h000280E7;
  localparam logic [31:0] I_CSR  = 32'h300110F3;

  initial begin
    id_ex_t nop;
    id_ex_t lui_e;
    id_ex_t addi_e;
    id_ex_t csr_e;
    nop = '0;
    addi_e = mk(I_ADDI, 32'h40, ALU_ADD, 32'd1000, 32'd5, 32'd7,
                MEN_X, 1'b1, WB_ALU, 5'd1, CSR_X, 1'b0);
    lui_e = mk(I_LUI, 32'h54, ALU_ADD, 32'd0, 32'h12345000, 32'h33,
               MEN_X, 1'b1, WB_ALU, 5'd3, CSR_X, 1'b0);
`ifdef DECODE_CSR_EN
    csr_e = mk(I_CSR, 32'h80, ALU_COPY1, 32'hAB, 32'd0, 32'd0,
               MEN_X, 1'b1, WB_CSR, 5'd1, CSR_W, 1'b0);
`else
    csr_e = nop;
`endif

    step(1'b0, 1'b0, 1'b0, I_ADDI, 32'h40, 32'd1000, 32'd7, nop);
    step(1'b0, 1'b0, 1'b0, I_ADDI, 32'h40, 32'd1000, 32'd7, nop);
    step(1'b1, 1'b0, 1'b0, I_ADDI, 32'h40, 32'd1000, 32'd7, addi_e);
    step(1'b1, 1'b0, 1'b0, I_SW, 32'h44, 32'h1000, 32'hDEADBEEF,
         mk(I_SW, 32'h44, ALU_ADD, 32'h1000, 32'd8, 32'hDEADBEEF,
            MEN_SW, 1'b0, WB_X, 5'd0, CSR_X, 1'b0));
    step(1'b1, 1'b0, 1'b0, I_BEQ, 32'h48, 32'h55, 32'h55,
         mk(I_BEQ, 32'h48, ALU_BEQ, 32'd0, 32'd0, 32'd0,
            MEN_X, 1'b0, WB_X, 5'd0, CSR_X, 1'b0));
    step(1'b1, 1'b0, 1'b0, I_JAL, 32'h100, 32'h11, 32'h22,
         mk(I_JAL, 32'h100, ALU_ADD, 32'h100, 32'hFFFFFFFC, 32'h22,
            MEN_X, 1'b1, WB_PC, 5'd1, CSR_X, 1'b1));
    step(1'b1, 1'b0, 1'b0, I_LUI, 32'h54, 32'h11, 32'h33, lui_e);
    step(1'b1, 1'b1, 1'b0, I_ADDI, 32'h58, 32'd1000, 32'd7, lui_e);
    step(1'b1, 1'b1, 1'b1, I_ADDI, 32'h58, 32'd1000, 32'd7, nop);
    step(1'b1, 1'b0, 1'b0, I_ADD, 32'h60, 32'd10, 32'd20,
         mk(I_ADD, 32'h60, ALU_ADD, 32'd10, 32'd20, 32'd20,
            MEN_X, 1'b1, WB_ALU, 5'd4, CSR_X, 1'b0));
    step(1'b1, 1'b0, 1'b0, I_SUB, 32'h64, 32'd50, 32'd8,
         mk(I_SUB, 32'h64, ALU_SUB, 32'd50, 32'd8, 32'd8,
            MEN_X, 1'b1, WB_ALU, 5'd4, CSR_X, 1'b0));
    step(1'b1, 1'b0, 1'b0, I_LBU, 32'h68, 32'h2000, 32'h44,
         mk(I_LBU, 32'h68, ALU_ADD, 32'h2000, 32'd4, 32'h44,
            MEN_X, 1'b1, WB_LBU, 5'd5, CSR_X, 1'b0));
    step(1'b1, 1'b0, 1'b0, I_BAD, 32'h6c, 32'h1, 32'h2, nop);
    step(1'b1, 1'b0, 1'b0, I_JALR, 32'h200, 32'h300, 32'h99,
         mk(I_JALR, 32'h200, ALU_JALR, 32'h300, 32'd0, 32'd0,
            MEN_X, 1'b1, WB_PC, 5'd1, CSR_X, 1'b1));
    step(1'b1, 1'b0, 1'b0, I_CSR, 32'h80, 32'hAB, 32'hCD, csr_e);
    step(1'b0, 1'b0, 1'b0, I_ADDI, 32'h40, 32'd1000, 32'd7, nop);
    step(1'b1, 1'b0, 1'b0, I_ADDI, 32'h40, 32'd1000, 32'd7, addi_e);

    repeat (3) @(posedge clk);
    #2;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
